// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: FSM encoding,
// default widths and the ID/EXE payload and control-vector field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_W  = 96;
  localparam int DEF_CTRL_W  = 4;
  localparam int DEF_STALL_W = 16;

  // ID/EXE payload layout inside in_data (bits 93..95 are spare)
  localparam int IDEX_ALUOP_LSB = 0;
  localparam int IDEX_ALUOP_W   = 4;
  localparam int IDEX_A_LSB     = 4;
  localparam int IDEX_A_W       = 32;
  localparam int IDEX_B_LSB     = 36;
  localparam int IDEX_B_W       = 32;
  localparam int IDEX_IMM_LSB   = 68;
  localparam int IDEX_IMM_W     = 16;
  localparam int IDEX_RD_LSB    = 84;
  localparam int IDEX_RD_W      = 5;
  localparam int IDEX_ACTRL_LSB = 89;
  localparam int IDEX_ACTRL_W   = 2;
  localparam int IDEX_BCTRL_LSB = 91;
  localparam int IDEX_BCTRL_W   = 2;

  // Side-effect control vector bit positions
  localparam int CTRL_WMEM  = 0;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WREG  = 2;
  localparam int CTRL_WZ    = 3;

  function automatic logic [DEF_CTRL_W-1:0] pack_ctrl(input logic wz, input logic wreg,
                                                      input logic m2reg, input logic wmem);
    return {wz, wreg, m2reg, wmem};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry plus the EMPTY/ONE/TWO occupancy state of a skid-mode stage.
// The skid entry is always younger than the main entry held by the parent.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              accept,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output pipe_state_e       state_o,
  output logic              skid_valid_o,
  output logic [DATA_W-1:0] skid_data_o,
  output logic [CTRL_W-1:0] skid_ctrl_o
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Occupancy transitions; the skid slot only fills when ONE accepts without popping
  always_comb begin
    state_d     = state_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_d = ST_ONE;
          else        state_d = ST_EMPTY;
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop && !accept) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop) state_d = ST_ONE;
          else     state_d = ST_TWO;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and skid entry registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_EMPTY;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign state_o      = state_q;
  assign skid_valid_o = (state_q == ST_TWO);
  assign skid_data_o  = skid_data_q;
  assign skid_ctrl_o  = skid_ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with optional skid buffer, flush,
// bubble-safe control gating and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int SKID    = 1,
  parameter int STALL_W = DEF_STALL_W
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [STALL_W-1:0] stall_cnt
);

  logic               main_valid_q, main_valid_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               accept, pop;
  pipe_state_e        state;
  logic               skid_valid;
  logic [DATA_W-1:0]  skid_data;
  logic [CTRL_W-1:0]  skid_ctrl;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (&v) return v;
    else    return v + STALL_W'(1);
  endfunction

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
      ) u_skid (
        .clk         (clk),
        .clrn        (clrn),
        .flush       (flush),
        .accept      (accept),
        .pop         (pop),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .state_o     (state),
        .skid_valid_o(skid_valid),
        .skid_data_o (skid_data),
        .skid_ctrl_o (skid_ctrl)
      );
      // Ready comes from stored occupancy only, never from out_ready
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign state      = ST_EMPTY;
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = ~main_valid_q | out_ready;
    end
  endgenerate

  assign accept = in_valid & in_ready;
  assign pop    = main_valid_q & out_ready;

  // Head entry update; flush discards both held entries and any accepted input
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end else if (SKID == 0) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end else begin
      case (state)
        ST_EMPTY, ST_ONE: begin
          if (accept && (pop || (state == ST_EMPTY))) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
          end else if (pop && !accept) begin
            main_valid_d = 1'b0;
          end else begin
            main_valid_d = main_valid_q;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data;
            main_ctrl_d  = skid_ctrl;
          end else begin
            main_valid_d = main_valid_q;
          end
        end
        default: main_valid_d = 1'b0;
      endcase
    end
  end

  // Stall counter survives flush; only reset clears it
  always_comb begin
    if (main_valid_q && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    else                            stall_cnt_d = stall_cnt_q;
  end

  // Head entry and stall counter registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid-mode instance (A) and a single-entry
// instance with a 4-bit stall counter (B), both checked against FIFO models.
module tb_pipe_stage_reg;

  localparam int AW = 96;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [AW-1:0] a_in_data, a_out_data;
  logic [3:0]    a_in_ctrl, a_out_ctrl;
  logic [15:0]   a_stall;

  logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [BW-1:0] b_in_data, b_out_data;
  logic [3:0]    b_in_ctrl, b_out_ctrl;
  logic [3:0]    b_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [AW-1:0] d; logic [3:0] c;} ent_a_t;
  typedef struct {logic [BW-1:0] d; logic [3:0] c;} ent_b_t;
  ent_a_t qa[$];
  ent_b_t qb[$];
  int sa = 0;
  int sb = 0;

  pipe_stage_reg #(.DATA_W(AW), .CTRL_W(4), .SKID(1), .STALL_W(16)) dut_a (
    .clk(clk), .clrn(clrn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.DATA_W(BW), .CTRL_W(4), .SKID(0), .STALL_W(4)) dut_b (
    .clk(clk), .clrn(clrn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .stall_cnt(b_stall)
  );

  // Reference: a FIFO of capacity 2 (A) or 1 (B) with a saturating stall count
  task automatic model_step();
    ent_a_t ea;
    ent_b_t eb;
    logic   acc;
    if (!clrn) begin
      qa.delete(); qb.delete(); sa = 0; sb = 0;
    end else begin
      acc = a_in_valid && (qa.size() < 2);
      if (qa.size() > 0 && !a_out_ready && sa < 65535) sa++;
      if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
      ea.d = a_in_data; ea.c = a_in_ctrl;
      if (a_flush) qa.delete();
      else if (acc) qa.push_back(ea);

      acc = b_in_valid && (qb.size() == 0 || b_out_ready);
      if (qb.size() > 0 && !b_out_ready && sb < 15) sb++;
      if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
      eb.d = b_in_data; eb.c = b_in_ctrl;
      if (b_flush) qb.delete();
      else if (acc) qb.push_back(eb);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = 4'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = 4'b0; b_flush = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %0b exp 0", a_out_valid); end
    checks++; if (a_out_ctrl !== 4'b0) begin errors++; $display("FAIL reset_a_out_ctrl got %h exp 0", a_out_ctrl); end
    checks++; if (a_out_data !== {AW{1'b0}}) begin errors++; $display("FAIL reset_a_out_data got %h exp 0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %0b exp 1", a_in_ready); end
    checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL reset_a_stall got %0d exp 0", a_stall); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %0b exp 0", b_out_valid); end
    checks++; if (b_out_ctrl !== 4'b0) begin errors++; $display("FAIL reset_b_out_ctrl got %h exp 0", b_out_ctrl); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got %0b exp 1", b_in_ready); end
    checks++; if (b_stall !== 4'd0) begin errors++; $display("FAIL reset_b_stall got %0d exp 0", b_stall); end
    clrn = 1'b1;
    qa.delete(); qb.delete(); sa = 0; sb = 0;
  endtask

  task automatic test_saturation();
    idle_inputs();
    b_in_valid = 1'b1; b_in_data = 16'h00AA; b_in_ctrl = 4'b0110;
    tick();
    b_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (b_stall !== 4'(sb)) begin errors++; $display("FAIL sat_step%0d got %0d exp %0d", i, b_stall, sb); end
    end
    checks++; if (b_stall !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", b_stall); end
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h00AA) begin
      errors++; $display("FAIL sat_hold got v=%0b d=%h exp v=1 d=00aa", b_out_valid, b_out_data);
    end
    b_out_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_stream();
    idle_inputs();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = AW'(i); a_in_ctrl = 4'b1010;
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== AW'(i) || a_out_ctrl !== 4'b1010) begin
        errors++; $display("FAIL stream_%0d got v=%0b d=%0d c=%b exp v=1 d=%0d c=1010", i, a_out_valid, a_out_data, a_out_ctrl, i);
      end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %0b exp 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'b0) begin
      errors++; $display("FAIL stream_drain got v=%0b c=%b exp v=0 c=0000", a_out_valid, a_out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    a_in_valid = 1'b1; a_in_data = AW'(5); a_in_ctrl = 4'b1010;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_out_data !== AW'(5)) begin
      errors++; $display("FAIL bp_first got rdy=%0b d=%0d exp rdy=1 d=5", a_in_ready, a_out_data);
    end
    a_in_data = AW'(6);
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", a_in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_stall !== 16'(sa) || a_out_data !== AW'(5)) begin
        errors++; $display("FAIL bp_hold%0d got stall=%0d d=%0d exp stall=%0d d=5", i, a_stall, a_out_data, sa);
      end
    end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== AW'(6) || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%0b d=%0d rdy=%0b exp v=1 d=6 rdy=1", a_out_valid, a_out_data, a_in_ready);
    end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", a_out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    a_in_valid = 1'b1; a_in_ctrl = 4'b0101;
    a_in_data = AW'(3); tick();
    a_in_data = AW'(4); tick();
    a_in_data = AW'(9); a_in_ctrl = 4'b1111; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'b0) begin
      errors++; $display("FAIL flush_bubble got v=%0b c=%b exp v=0 c=0000", a_out_valid, a_out_ctrl);
    end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", a_in_ready); end
    checks++; if (a_stall !== 16'(sa)) begin errors++; $display("FAIL flush_stall_kept got %0d exp %0d", a_stall, sa); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_out_data === AW'(9)) begin
        errors++; $display("FAIL flush_no_d9_%0d got v=%0b d=%0d exp v=0 d!=9", i, a_out_valid, a_out_data);
      end
    end
    a_in_valid = 1'b1; a_in_data = AW'(10); a_in_ctrl = 4'b0011;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== AW'(10) || a_out_ctrl !== 4'b0011) begin
      errors++; $display("FAIL flush_recover got v=%0b d=%0d c=%b exp v=1 d=10 c=0011", a_out_valid, a_out_data, a_out_ctrl);
    end
    tick();
  endtask

  task automatic test_noskid();
    logic [11:0]   pat;
    logic [BW-1:0] k;
    logic          exp_rdy;
    idle_inputs();
    pat = 12'b1010_0110_1101;
    k = 16'h0100;
    for (int i = 0; i < 12; i++) begin
      b_in_valid = 1'b1; b_in_data = k; b_in_ctrl = 4'b0011; b_out_ready = pat[i];
      #1;
      exp_rdy = (qb.size() == 0) || pat[i];
      checks++; if (b_in_ready !== exp_rdy) begin errors++; $display("FAIL noskid_ready_%0d got %0b exp %0b", i, b_in_ready, exp_rdy); end
      tick();
      if (exp_rdy) k = k + 16'd1;
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== qb[0].d) begin
        errors++; $display("FAIL noskid_out_%0d got v=%0b d=%h exp v=1 d=%h", i, b_out_valid, b_out_data, qb[0].d);
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL noskid_drain got %0b exp 0", b_out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] ec;
    for (int n = 0; n < 400; n++) begin
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush = ($urandom_range(0, 24) == 0);
      a_in_data = {$urandom, $urandom, $urandom};
      a_in_ctrl = 4'($urandom_range(0, 15));
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush = ($urandom_range(0, 24) == 0);
      b_in_data = 16'($urandom);
      b_in_ctrl = 4'($urandom_range(0, 15));
      tick();
      ec = (qa.size() > 0) ? qa[0].c : 4'b0;
      checks++; if (a_out_valid !== (qa.size() > 0) || a_out_ctrl !== ec) begin
        errors++; $display("FAIL rand_a_out n=%0d got v=%0b c=%b exp v=%0b c=%b", n, a_out_valid, a_out_ctrl, qa.size() > 0, ec);
      end
      if (qa.size() > 0) begin
        checks++; if (a_out_data !== qa[0].d) begin errors++; $display("FAIL rand_a_data n=%0d got %h exp %h", n, a_out_data, qa[0].d); end
      end
      checks++; if (a_in_ready !== (qa.size() < 2) || a_stall !== 16'(sa)) begin
        errors++; $display("FAIL rand_a_rdy_stall n=%0d got rdy=%0b st=%0d exp rdy=%0b st=%0d", n, a_in_ready, a_stall, qa.size() < 2, sa);
      end
      ec = (qb.size() > 0) ? qb[0].c : 4'b0;
      checks++; if (b_out_valid !== (qb.size() > 0) || b_out_ctrl !== ec) begin
        errors++; $display("FAIL rand_b_out n=%0d got v=%0b c=%b exp v=%0b c=%b", n, b_out_valid, b_out_ctrl, qb.size() > 0, ec);
      end
      if (qb.size() > 0) begin
        checks++; if (b_out_data !== qb[0].d) begin errors++; $display("FAIL rand_b_data n=%0d got %h exp %h", n, b_out_data, qb[0].d); end
      end
      checks++; if (b_in_ready !== ((qb.size() == 0) || b_out_ready) || b_stall !== 4'(sb)) begin
        errors++; $display("FAIL rand_b_rdy_stall n=%0d got rdy=%0b st=%0d exp st=%0d", n, b_in_ready, b_stall, sb);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom}; a_in_ctrl = 4'b1111;
    b_in_valid = 1'b1; b_in_data = 16'hBEEF; b_in_ctrl = 4'b1111;
    tick();
    tick();
    idle_inputs();
    #2 clrn = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'b0 || a_out_data !== {AW{1'b0}}) begin
      errors++; $display("FAIL areset_a_out got v=%0b c=%b d=%h exp all 0", a_out_valid, a_out_ctrl, a_out_data);
    end
    checks++; if (a_stall !== 16'd0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_a_misc got st=%0d rdy=%0b exp st=0 rdy=1", a_stall, a_in_ready);
    end
    checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 4'b0 || b_stall !== 4'd0 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_b got v=%0b c=%b st=%0d rdy=%0b exp 0 0 0 1", b_out_valid, b_out_ctrl, b_stall, b_in_ready);
    end
    qa.delete(); qb.delete(); sa = 0; sb = 0;
    @(negedge clk);
    clrn = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_after got a=%0b b=%0b exp 0 0", a_out_valid, b_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
